// File: rtl/hs_npu_axi_sram_responder_pkg.sv
// Shared AXI encodings and responder state type for the NPU SRAM responder.
package hs_npu_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } axi_resp_e;

   typedef enum logic [1:0] {
      FIXED = 2'b00,
      INCR  = 2'b01,
      WRAP  = 2'b10
   } axi_burst_e;

   localparam logic [2:0] AXI_SIZE_WORD = 3'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WR_DATA,
      ST_WR_RESP,
      ST_RD_DATA
   } rsp_state_e;

   // Only full-word incrementing bursts touch the SRAM; anything else answers SLVERR.
   function automatic logic burst_legal(input logic [2:0] size, input logic [1:0] burst);
      return (size == AXI_SIZE_WORD) && (burst == INCR);
   endfunction

endpackage

// File: rtl/hs_npu_axi_sram_responder_if.sv
// AXI4 burst bus (AR/R/AW/W/B) with 32-bit data between the NPU master and a responder.
interface axib_if #(parameter int ID_W = 4);

   logic            arvalid;
   logic            arready;
   logic [31:0]     araddr;
   logic [7:0]      arlen;
   logic [2:0]      arsize;
   logic [1:0]      arburst;
   logic [ID_W-1:0] arid;

   logic            rvalid;
   logic            rready;
   logic [31:0]     rdata;
   logic [1:0]      rresp;
   logic            rlast;
   logic [ID_W-1:0] rid;

   logic            awvalid;
   logic            awready;
   logic [31:0]     awaddr;
   logic [7:0]      awlen;
   logic [2:0]      awsize;
   logic [1:0]      awburst;
   logic [ID_W-1:0] awid;

   logic            wvalid;
   logic            wready;
   logic [31:0]     wdata;
   logic [3:0]      wstrb;
   logic            wlast;

   logic            bvalid;
   logic            bready;
   logic [1:0]      bresp;
   logic [ID_W-1:0] bid;

   modport m (
      output arvalid, araddr, arlen, arsize, arburst, arid,
      input  arready,
      input  rvalid, rdata, rresp, rlast, rid,
      output rready,
      output awvalid, awaddr, awlen, awsize, awburst, awid,
      input  awready,
      output wvalid, wdata, wstrb, wlast,
      input  wready,
      input  bvalid, bresp, bid,
      output bready
   );

   modport s (
      input  arvalid, araddr, arlen, arsize, arburst, arid,
      output arready,
      output rvalid, rdata, rresp, rlast, rid,
      input  rready,
      input  awvalid, awaddr, awlen, awsize, awburst, awid,
      output awready,
      input  wvalid, wdata, wstrb, wlast,
      output wready,
      output bvalid, bresp, bid,
      input  bready
   );

endinterface

// File: rtl/hs_npu_axi_sram_responder_bytewr.sv
// DEPTH x 32-bit word SRAM: one byte-enabled write port, one registered read port.
module hs_npu_sram_bytewr #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   // Byte-lane write; a zero byte-enable mask leaves the word untouched.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // Read data appears the cycle after re and holds until the next re.
   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/hs_npu_axi_sram_responder.sv
// AXI4 burst responder backed by on-chip SRAM; one burst in flight, writes win over reads.
module hs_npu_axi_sram_responder
   import hs_npu_pkg::*;
#(
   parameter int          DEPTH     = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          ID_W      = 4
) (
   input  logic clk,
   input  logic rst,
   axib_if.s    axi,
   output logic busy_o
);

   localparam int          AW        = $clog2(DEPTH);
   localparam logic [31:0] WIN_BYTES = 32'(4 * DEPTH);

   function automatic logic in_window(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE_ADDR;
      return off < WIN_BYTES;
   endfunction

   function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE_ADDR;
      return AW'(off >> 2);
   endfunction

   rsp_state_e      state_q, state_d;
   logic [7:0]      cnt_q, nxt_cnt, len_q;
   logic [31:0]     addr_q;
   logic [ID_W-1:0] id_q;
   logic            legal_q;
   logic            err_sticky_q;
   logic            werr_q;
   logic            rvalid_q, rerr_q, rlast_q;
   logic            bvalid_q, berr_q;

   logic            ar_hs, aw_hs, w_hs, r_hs, b_hs;
   logic            w_is_len, w_end, wlast_bad;
   logic [31:0]     beat_addr;
   logic            beat_legal, beat_ok;
   logic            sram_we, sram_re;
   logic [AW-1:0]   sram_waddr, sram_raddr;
   logic [31:0]     sram_q;

   assign ar_hs     = axi.arvalid && axi.arready;
   assign aw_hs     = axi.awvalid && axi.awready;
   assign w_hs      = axi.wvalid  && axi.wready;
   assign r_hs      = rvalid_q    && axi.rready;
   assign b_hs      = bvalid_q    && axi.bready;
   assign nxt_cnt   = cnt_q + 8'd1;
   assign w_is_len  = (cnt_q == len_q);
   assign w_end     = w_is_len || axi.wlast;
   assign wlast_bad = (axi.wlast != w_is_len);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next state and channel readies; no handshake is offered while reset is asserted.
   always_comb begin
      state_d     = state_q;
      axi.arready = 1'b0;
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!rst) begin
               if (axi.awvalid) begin
                  axi.awready = 1'b1;
                  state_d     = ST_WR_DATA;
               end else if (axi.arvalid) begin
                  axi.arready = 1'b1;
                  state_d     = ST_RD_DATA;
               end
            end
         end
         ST_WR_DATA: begin
            axi.wready = !rst;
            if (axi.wvalid && !rst && w_end) state_d = ST_WR_RESP;
         end
         ST_WR_RESP: begin
            if (b_hs) state_d = ST_IDLE;
         end
         ST_RD_DATA: begin
            if (r_hs && rlast_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Beat address: the AR address on a new read, the following beat while a read
   // is streaming, otherwise the current write beat.
   always_comb begin
      beat_addr  = addr_q + {22'd0, cnt_q, 2'b00};
      beat_legal = legal_q;
      if (state_q == ST_IDLE) begin
         beat_addr  = axi.araddr;
         beat_legal = burst_legal(axi.arsize, axi.arburst);
      end else if (state_q == ST_RD_DATA) begin
         beat_addr  = addr_q + {22'd0, nxt_cnt, 2'b00};
      end
   end

   assign beat_ok    = beat_legal && in_window(beat_addr);
   assign sram_we    = w_hs && beat_ok;
   assign sram_waddr = word_idx(beat_addr);
   assign sram_re    = (ar_hs || (r_hs && !rlast_q)) && beat_ok;
   assign sram_raddr = word_idx(beat_addr);

   hs_npu_sram_bytewr #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_sram (
      .clk   (clk),
      .we    (sram_we),
      .be    (axi.wstrb),
      .waddr (sram_waddr),
      .wdata (axi.wdata),
      .re    (sram_re),
      .raddr (sram_raddr),
      .rdata (sram_q)
   );

   // Burst attributes captured at the address handshake.
   always_ff @(posedge clk) begin
      if (aw_hs) begin
         addr_q  <= axi.awaddr;
         len_q   <= axi.awlen;
         legal_q <= burst_legal(axi.awsize, axi.awburst);
      end else if (ar_hs) begin
         addr_q  <= axi.araddr;
         len_q   <= axi.arlen;
         legal_q <= burst_legal(axi.arsize, axi.arburst);
      end
   end

   // Beat counter, error tracking and R/B channel valids.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= 8'd0;
         id_q         <= '0;
         err_sticky_q <= 1'b0;
         werr_q       <= 1'b0;
         rvalid_q     <= 1'b0;
         rerr_q       <= 1'b0;
         rlast_q      <= 1'b0;
         bvalid_q     <= 1'b0;
         berr_q       <= 1'b0;
      end else if (aw_hs) begin
         cnt_q        <= 8'd0;
         id_q         <= axi.awid;
         err_sticky_q <= 1'b0;
         werr_q       <= 1'b0;
      end else if (ar_hs) begin
         cnt_q        <= 8'd0;
         id_q         <= axi.arid;
         err_sticky_q <= 1'b0;
         rvalid_q     <= 1'b1;
         rerr_q       <= !beat_ok;
         rlast_q      <= (axi.arlen == 8'd0);
      end else if (w_hs) begin
         cnt_q        <= nxt_cnt;
         werr_q       <= werr_q || !beat_ok;
         err_sticky_q <= err_sticky_q || wlast_bad;
         if (w_end) begin
            bvalid_q <= 1'b1;
            berr_q   <= werr_q || err_sticky_q || !beat_ok || wlast_bad;
         end
      end else if (r_hs) begin
         if (rlast_q) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rerr_q   <= 1'b0;
         end else begin
            cnt_q    <= nxt_cnt;
            rerr_q   <= !beat_ok;
            rlast_q  <= (nxt_cnt == len_q);
         end
      end else if (b_hs) begin
         bvalid_q <= 1'b0;
         berr_q   <= 1'b0;
      end
   end

   assign axi.rvalid = rvalid_q;
   assign axi.rdata  = (rvalid_q && !rerr_q) ? sram_q : 32'h0;
   assign axi.rresp  = rerr_q ? SLVERR : OKAY;
   assign axi.rlast  = rlast_q;
   assign axi.rid    = id_q;
   assign axi.bvalid = bvalid_q;
   assign axi.bresp  = berr_q ? SLVERR : OKAY;
   assign axi.bid    = id_q;
   assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hs_npu_axi_sram_responder.sv
// Scoreboard bench for the AXI SRAM responder: a shadow word memory predicts R and B beats.
module tb_hs_npu_axi_sram_responder;

   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] d;
      logic [1:0]  resp;
      logic        last;
      logic [3:0]  id;
   } rexp_t;

   typedef struct packed {
      logic [1:0] resp;
      logic [3:0] id;
   } bexp_t;

   logic clk = 1'b0;
   logic rst;
   logic busy;

   axib_if #(.ID_W(4)) bus();

   hs_npu_axi_sram_responder #(
      .DEPTH     (DEPTH),
      .BASE_ADDR (BASE),
      .ID_W      (4)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .axi    (bus.s),
      .busy_o (busy)
   );

   always #5 clk = ~clk;

   int          n_chk  = 0;
   int          n_pass = 0;
   rexp_t       rq[$];
   bexp_t       bq[$];
   logic [31:0] smem [int];
   logic [31:0] wd [16];
   logic [3:0]  ws [16];
   logic [31:0] cur_addr;
   logic [7:0]  cur_len;
   logic        cur_legal;
   logic [3:0]  cur_id;
   logic        ar_at_aw;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic win(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return off < 32'(4 * DEPTH);
   endfunction

   function automatic int widx(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return int'(off >> 2);
   endfunction

   // Scoreboard: compare every R and B handshake against the oldest prediction.
   always @(negedge clk) begin : mon
      rexp_t e;
      bexp_t f;
      if (!rst && bus.rvalid && bus.rready) begin
         if (rq.size() == 0) chk("r_unexpected", rq.size(), 1);
         else begin
            e = rq.pop_front();
            chk("rdata", bus.rdata, e.d);
            chk("rresp", bus.rresp, e.resp);
            chk("rlast", bus.rlast, e.last);
            chk("rid", bus.rid, e.id);
         end
      end
      if (!rst && bus.bvalid && bus.bready) begin
         if (bq.size() == 0) chk("b_unexpected", bq.size(), 1);
         else begin
            f = bq.pop_front();
            chk("bresp", bus.bresp, f.resp);
            chk("bid", bus.bid, f.id);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic wr_aw(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                        input logic [1:0] bu, input logic [3:0] id);
      int n = 0;
      cur_addr = a; cur_len = len; cur_id = id;
      cur_legal = (sz == 3'd2) && (bu == 2'b01);
      bus.awaddr = a; bus.awlen = len; bus.awsize = sz; bus.awburst = bu; bus.awid = id;
      bus.awvalid = 1'b1;
      @(negedge clk);
      while (!bus.awready && n < 50) begin @(negedge clk); n++; end
      ar_at_aw = bus.arready;
      if (!bus.awready) begin
         chk("aw_handshake", bus.awready, 1);
         bus.awvalid = 1'b0;
      end else begin
         @(posedge clk); #1;
         bus.awvalid = 1'b0;
      end
   endtask

   task automatic wr_data(input logic [7:0] wlast_at);
      int          nb;
      logic        err = 1'b0;
      logic [31:0] ak, w;
      int          n;
      bexp_t       f;
      nb = (wlast_at < cur_len) ? int'(wlast_at) + 1 : int'(cur_len) + 1;
      for (int k = 0; k < nb; k++) begin
         ak = cur_addr + 32'(4 * k);
         bus.wdata = wd[k]; bus.wstrb = ws[k]; bus.wlast = (k == int'(wlast_at));
         bus.wvalid = 1'b1;
         n = 0;
         @(negedge clk);
         while (!bus.wready && n < 50) begin @(negedge clk); n++; end
         if (!bus.wready) chk("w_handshake", bus.wready, 1);
         @(posedge clk); #1;
         if (cur_legal && win(ak)) begin
            w = smem.exists(widx(ak)) ? smem[widx(ak)] : 32'h0;
            for (int b = 0; b < 4; b++) if (ws[k][b]) w[8*b +: 8] = wd[k][8*b +: 8];
            smem[widx(ak)] = w;
         end else err = 1'b1;
      end
      bus.wvalid = 1'b0; bus.wlast = 1'b0;
      if (wlast_at != cur_len) err = 1'b1;
      f.resp = err ? 2'b10 : 2'b00;
      f.id   = cur_id;
      bq.push_back(f);
   endtask

   task automatic b_drain();
      int n = 0;
      while (bq.size() != 0 && n < 60) begin @(posedge clk); n++; end
      #1;
      chk("b_drain", bq.size(), 0);
   endtask

   task automatic wr_burst(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] bu, input logic [3:0] id, input logic [7:0] wlast_at);
      wr_aw(a, len, sz, bu, id);
      wr_data(wlast_at);
      b_drain();
   endtask

   task automatic rd_push(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                          input logic [1:0] bu, input logic [3:0] id);
      rexp_t       e;
      logic [31:0] ak;
      logic        legal;
      legal = (sz == 3'd2) && (bu == 2'b01);
      for (int k = 0; k <= int'(len); k++) begin
         ak = a + 32'(4 * k);
         e.id   = id;
         e.last = (k == int'(len));
         if (legal && win(ak)) begin
            e.resp = 2'b00;
            e.d    = smem.exists(widx(ak)) ? smem[widx(ak)] : 32'h0;
         end else begin
            e.resp = 2'b10;
            e.d    = 32'h0;
         end
         rq.push_back(e);
      end
   endtask

   task automatic ar_go(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                        input logic [1:0] bu, input logic [3:0] id);
      int n = 0;
      bus.araddr = a; bus.arlen = len; bus.arsize = sz; bus.arburst = bu; bus.arid = id;
      bus.arvalid = 1'b1;
      @(negedge clk);
      while (!bus.arready && n < 50) begin @(negedge clk); n++; end
      if (!bus.arready) chk("ar_handshake", bus.arready, 1);
      else @(posedge clk);
      #1;
      bus.arvalid = 1'b0;
   endtask

   task automatic r_drain();
      int n = 0;
      while (rq.size() != 0 && n < 100) begin @(posedge clk); n++; end
      #1;
      chk("r_drain", rq.size(), 0);
   endtask

   task automatic rd_burst(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] bu, input logic [3:0] id);
      rd_push(a, len, sz, bu, id);
      ar_go(a, len, sz, bu, id);
      r_drain();
   endtask

   initial begin
      rst = 1'b1;
      bus.arvalid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 3'd2; bus.arburst = 2'b01; bus.arid = 0;
      bus.awvalid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 3'd2; bus.awburst = 2'b01; bus.awid = 0;
      bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0;
      bus.rready = 1'b1; bus.bready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_arready", bus.arready, 0);
      chk("rst_awready", bus.awready, 0);
      chk("rst_wready", bus.wready, 0);
      chk("rst_rvalid", bus.rvalid, 0);
      chk("rst_bvalid", bus.bvalid, 0);
      chk("rst_rlast", bus.rlast, 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_rresp", bus.rresp, 0);
      chk("rst_bresp", bus.bresp, 0);
      chk("rst_rid", bus.rid, 0);
      chk("rst_bid", bus.bid, 0);
      chk("rst_busy", busy, 0);
      @(posedge clk); #1;

      // 1: two-beat write and read back
      wd[0] = 32'hDEAD_BEEF; wd[1] = 32'h1234_5678; ws[0] = 4'hF; ws[1] = 4'hF;
      wr_burst(32'h10, 8'd1, 3'd2, 2'b01, 4'd3, 8'd1);
      rd_burst(32'h10, 8'd1, 3'd2, 2'b01, 4'd5);

      // 2: simultaneous AW and AR, write wins, read sees new data
      bus.araddr = 32'h10; bus.arlen = 8'd1; bus.arsize = 3'd2; bus.arburst = 2'b01; bus.arid = 4'd6;
      bus.arvalid = 1'b1;
      wd[0] = 32'hCAFE_F00D; ws[0] = 4'hF;
      wr_aw(32'h10, 8'd0, 3'd2, 2'b01, 4'd2);
      chk("aw_priority_arready", ar_at_aw, 0);
      chk("busy_in_write", busy, 1);
      wr_data(8'd0);
      b_drain();
      rd_push(32'h10, 8'd1, 3'd2, 2'b01, 4'd6);
      ar_go(32'h10, 8'd1, 3'd2, 2'b01, 4'd6);
      r_drain();

      // 3: partial strobe
      wd[0] = 32'hAAAA_AAAA; ws[0] = 4'hF;
      wr_burst(32'h20, 8'd0, 3'd2, 2'b01, 4'd1, 8'd0);
      wd[0] = 32'h5555_5555; ws[0] = 4'b0011;
      wr_burst(32'h20, 8'd0, 3'd2, 2'b01, 4'd1, 8'd0);
      rd_burst(32'h20, 8'd0, 3'd2, 2'b01, 4'd4);

      // 4: rready back-pressure on beat 0
      for (int k = 0; k < 4; k++) begin wd[k] = 32'h0BAD_0000 + 32'(k * 17); ws[k] = 4'hF; end
      wr_burst(32'h40, 8'd3, 3'd2, 2'b01, 4'd9, 8'd3);
      bus.rready = 1'b0;
      rd_push(32'h40, 8'd3, 3'd2, 2'b01, 4'd10);
      ar_go(32'h40, 8'd3, 3'd2, 2'b01, 4'd10);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("stall_rvalid", bus.rvalid, 1);
         chk("stall_rdata", bus.rdata, rq[0].d);
         chk("stall_rlast", bus.rlast, rq[0].last);
      end
      @(posedge clk); #1;
      bus.rready = 1'b1;
      r_drain();

      // 5: window top, illegal size, early wlast, illegal burst type
      wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222; ws[0] = 4'hF; ws[1] = 4'hF;
      wr_burst(BASE + 32'(4 * DEPTH - 4), 8'd1, 3'd2, 2'b01, 4'd1, 8'd1);
      rd_burst(BASE + 32'(4 * DEPTH - 4), 8'd1, 3'd2, 2'b01, 4'd2);
      rd_burst(32'h10, 8'd1, 3'd1, 2'b01, 4'd3);
      wd[0] = 32'h7777_0001; wd[1] = 32'h7777_0002;
      wr_burst(32'h60, 8'd1, 3'd2, 2'b01, 4'd4, 8'd0);
      rd_burst(32'h60, 8'd0, 3'd2, 2'b01, 4'd4);
      wd[0] = 32'h0; ws[0] = 4'hF;
      wr_burst(32'h20, 8'd0, 3'd2, 2'b00, 4'd5, 8'd0);
      rd_burst(32'h20, 8'd0, 3'd2, 2'b01, 4'd5);

      // 6: reset during write beat 0
      wr_aw(32'h80, 8'd1, 3'd2, 2'b01, 4'd7);
      bus.wdata = 32'hFEED_0000; bus.wstrb = 4'hF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; bus.wvalid = 1'b0;
      @(negedge clk);
      chk("post_rst_wready", bus.wready, 0);
      chk("post_rst_awready", bus.awready, 0);
      chk("post_rst_arready", bus.arready, 0);
      chk("post_rst_rvalid", bus.rvalid, 0);
      chk("post_rst_bvalid", bus.bvalid, 0);
      chk("post_rst_busy", busy, 0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("post_rst_no_b", bus.bvalid, 0);
      end
      @(posedge clk); #1;
      wd[0] = 32'hFEED_0001; wd[1] = 32'hFEED_0002; ws[0] = 4'hF; ws[1] = 4'b0101;
      wr_burst(32'h80, 8'd1, 3'd2, 2'b01, 4'd8, 8'd1);
      rd_burst(32'h80, 8'd1, 3'd2, 2'b01, 4'd8);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
